// File: rtl/rr_onehot_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : rr_onehot_arbiter_if                                            |
// | Purpose  : Request/grant bundle between the 16-line round-robin arbiter    |
// |            and its consumer (the 16-to-4 one-hot encoder stage).           |
// | Signals  : req[15:0]          requester -> arbiter, level-sensitive        |
// |            grant_ack          consumer  -> arbiter, release current grant  |
// |            grant_onehot[15:0] arbiter   -> consumer, zero or one-hot       |
// |            grant_valid        arbiter   -> consumer, encoder enable        |
// |            timeout            arbiter   -> consumer, revocation pulse      |
// | Modports : master = arbiter side, slave = requester/consumer side          |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface rr_onehot_arbiter_if;
   logic [15:0] req;
   logic        grant_ack;
   logic [15:0] grant_onehot;
   logic        grant_valid;
   logic        timeout;

   modport master (
      input  req,
      input  grant_ack,
      output grant_onehot,
      output grant_valid,
      output timeout
   );

   modport slave (
      output req,
      output grant_ack,
      input  grant_onehot,
      input  grant_valid,
      input  timeout
   );
endinterface
`default_nettype wire

// File: rtl/rr_onehot_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : rr_onehot_arbiter                                               |
// | Purpose  : Round-robin arbiter over 16 request lines. Issues a registered  |
// |            one-hot grant plus valid strobe and holds it until the consumer |
// |            acknowledges or (optionally) a hold timeout revokes it.         |
// | Ports    : clk        rising-edge clock                                    |
// |            rst_n      synchronous reset, active-low                        |
// |            arb        rr_onehot_arbiter_if.master (req, grant_ack in;      |
// |                       grant_onehot, grant_valid, timeout out)              |
// | Params   : MAX_HOLD   cycles a grant may be held without ack, 2..255       |
// |                       (used only in the timeout build)                     |
// | Macro    : RR_ONEHOT_ARBITER_TIMEOUT_EN enables the hold counter and       |
// |            timeout revocation; when undefined timeout is tied low.         |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module rr_onehot_arbiter #(
   parameter int unsigned MAX_HOLD = 64
) (
   input  logic                       clk,
   input  logic                       rst_n,
   rr_onehot_arbiter_if.master        arb
);

   if ((MAX_HOLD < 2) || (MAX_HOLD > 255)) begin : g_max_hold_range
      $error("rr_onehot_arbiter: MAX_HOLD must lie in 2..255");
   end

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_e;

   state_e      state_q;
   logic [3:0]  ptr_q;
   logic [3:0]  win_q;
   logic [15:0] grant_onehot_q;
   logic        grant_valid_q;
   logic        timeout_q;

   logic [15:0] rot_req;
   logic [3:0]  offs;
   logic [3:0]  win_d;
   logic        any_req;
   logic        expire;

   // Rotate the request vector so that index ptr lands at bit 0; the lowest
   // set bit of the rotated vector is then the distance from ptr to the
   // winner, and the 4-bit add wraps 15 -> 0 for free.
   always_comb begin
      rot_req = 16'({arb.req, arb.req} >> ptr_q);
      offs    = 4'd0;
      for (int i = 15; i >= 0; i--) begin
         if (rot_req[i]) begin
            offs = 4'(i);
         end
      end
      win_d = ptr_q + offs;
   end

   assign any_req = |arb.req;

`ifdef RR_ONEHOT_ARBITER_TIMEOUT_EN
   localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

   logic [7:0] hold_cnt_q;

   // hold_cnt is 0 in the first grant cycle, so reaching MAX_HOLD-1 means
   // grant_valid has been high for exactly MAX_HOLD cycles.
   assign expire = (hold_cnt_q == HOLD_LAST);
`else
   assign expire = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         ptr_q          <= 4'd0;
         win_q          <= 4'd0;
         grant_onehot_q <= 16'h0000;
         grant_valid_q  <= 1'b0;
         timeout_q      <= 1'b0;
`ifdef RR_ONEHOT_ARBITER_TIMEOUT_EN
         hold_cnt_q     <= 8'd0;
`endif
      end else begin
         timeout_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (any_req) begin
                  win_q          <= win_d;
                  grant_onehot_q <= 16'd1 << win_d;
                  grant_valid_q  <= 1'b1;
                  state_q        <= ST_GRANT;
`ifdef RR_ONEHOT_ARBITER_TIMEOUT_EN
                  hold_cnt_q     <= 8'd0;
`endif
               end
            end
            ST_GRANT: begin
               // Ack is tested first so a coincident expiry never pulses timeout.
               if (arb.grant_ack || expire) begin
                  grant_onehot_q <= 16'h0000;
                  grant_valid_q  <= 1'b0;
                  ptr_q          <= win_q + 4'd1;
                  timeout_q      <= ~arb.grant_ack;
                  state_q        <= ST_IDLE;
               end
`ifdef RR_ONEHOT_ARBITER_TIMEOUT_EN
               else begin
                  hold_cnt_q <= hold_cnt_q + 8'd1;
               end
`endif
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign arb.grant_onehot = grant_onehot_q;
   assign arb.grant_valid  = grant_valid_q;
   assign arb.timeout      = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_rr_onehot_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_rr_onehot_arbiter                                            |
// | Purpose  : Scoreboard bench for rr_onehot_arbiter. A driver applies        |
// |            directed and random req/ack/reset patterns and a reference      |
// |            model queues expected grant starts and releases; a monitor      |
// |            pops and compares them as the DUT presents them.                |
// | Macro    : RR_ONEHOT_ARBITER_TIMEOUT_EN selects the timeout expectations.  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_rr_onehot_arbiter;

   localparam int MAX_HOLD = 4;
`ifdef RR_ONEHOT_ARBITER_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   typedef struct {
      logic [15:0] mask;
      int          cyc;
   } grant_t;

   typedef struct {
      logic timed_out;
      int   cyc;
   } rel_t;

   logic clk = 1'b0;
   logic rst_n;
   int   edge_cnt = 0;
   int   total = 0;
   int   bad = 0;
   bit   mon_en = 1'b0;

   grant_t gq[$];
   rel_t   rq[$];

   // reference model state
   bit m_busy = 1'b0;
   int m_ptr = 0;
   int m_win = 0;
   int m_held = 0;

   rr_onehot_arbiter_if bus ();

   rr_onehot_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .arb   (bus.master)
   );

   always #5 clk = ~clk;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   // first requester found scanning upward from p with wrap
   function automatic int pick(input logic [15:0] r, input int p);
      for (int k = 0; k < 16; k++) begin
         if (r[(p + k) % 16]) return (p + k) % 16;
      end
      return -1;
   endfunction

   task automatic push_rel(input logic to);
      rel_t x;
      x.timed_out = to;
      x.cyc       = edge_cnt + 1;
      rq.push_back(x);
   endtask

   // One cycle: drive inputs at the falling edge and advance the model to
   // what the DUT must show after the next rising edge.
   task automatic step(input logic [15:0] r, input logic a, input logic rn);
      grant_t g;
      @(negedge clk);
      bus.req       = r;
      bus.grant_ack = a;
      rst_n         = rn;
      if (!rn) begin
         if (m_busy) push_rel(1'b0);
         m_busy = 1'b0;
         m_ptr  = 0;
         m_held = 0;
      end else if (!m_busy) begin
         if (r != 16'h0000) begin
            m_win  = pick(r, m_ptr);
            g.mask = 16'h0001 << m_win;
            g.cyc  = edge_cnt + 1;
            gq.push_back(g);
            m_busy = 1'b1;
            m_held = 1;
         end
      end else if (a) begin
         push_rel(1'b0);
         m_ptr  = (m_win + 1) % 16;
         m_busy = 1'b0;
      end else if (TO_EN && (m_held == MAX_HOLD)) begin
         push_rel(1'b1);
         m_ptr  = (m_win + 1) % 16;
         m_busy = 1'b0;
      end else begin
         m_held = m_held + 1;
      end
   endtask

   // monitor
   logic        prev_v = 1'b0;
   logic        cur_v;
   logic [15:0] held_mask = 16'h0000;
   grant_t      eg;
   rel_t        er;

   always @(negedge clk) begin
      if (mon_en) begin
         cur_v = bus.grant_valid;
         total++;
         if (cur_v && !prev_v) begin
            if (gq.size() == 0) begin
               bad++;
               $display("FAIL grant_start unexpected got=%h at edge %0d want=no grant",
                        bus.grant_onehot, edge_cnt);
            end else begin
               eg = gq.pop_front();
               if (bus.grant_onehot !== eg.mask || edge_cnt != eg.cyc) begin
                  bad++;
                  $display("FAIL grant_start got=%h@%0d want=%h@%0d",
                           bus.grant_onehot, edge_cnt, eg.mask, eg.cyc);
               end
            end
            held_mask = bus.grant_onehot;
         end else if (cur_v) begin
            if (bus.grant_onehot !== held_mask) begin
               bad++;
               $display("FAIL grant_hold got=%h want=%h at edge %0d",
                        bus.grant_onehot, held_mask, edge_cnt);
            end
         end else begin
            if (bus.grant_onehot !== 16'h0000) begin
               bad++;
               $display("FAIL idle_onehot got=%h want=0000 at edge %0d",
                        bus.grant_onehot, edge_cnt);
            end
         end
         total++;
         if (!cur_v && prev_v) begin
            if (rq.size() == 0) begin
               bad++;
               $display("FAIL grant_release unexpected at edge %0d timeout=%b",
                        edge_cnt, bus.timeout);
            end else begin
               er = rq.pop_front();
               if (bus.timeout !== er.timed_out || edge_cnt != er.cyc) begin
                  bad++;
                  $display("FAIL grant_release got timeout=%b@%0d want timeout=%b@%0d",
                           bus.timeout, edge_cnt, er.timed_out, er.cyc);
               end
            end
         end else if (bus.timeout !== 1'b0) begin
            bad++;
            $display("FAIL timeout_spurious got=%b want=0 at edge %0d",
                     bus.timeout, edge_cnt);
         end
         prev_v = cur_v;
      end
   end

   initial begin
      logic [15:0] r;
      int          mode;
      bus.req       = 16'h0000;
      bus.grant_ack = 1'b0;
      rst_n         = 1'b0;

      // reset state
      step(16'h0000, 1'b0, 1'b0);
      step(16'h0000, 1'b0, 1'b1);
      total++;
      if (bus.grant_valid !== 1'b0 || bus.grant_onehot !== 16'h0000 || bus.timeout !== 1'b0) begin
         bad++;
         $display("FAIL reset_state got v=%b g=%h t=%b want v=0 g=0000 t=0",
                  bus.grant_valid, bus.grant_onehot, bus.timeout);
      end
      mon_en = 1'b1;

      // reset mid-grant, then pointer back at 0
      step(16'h0010, 1'b0, 1'b1);
      step(16'h0010, 1'b0, 1'b1);
      step(16'h0010, 1'b0, 1'b0);
      step(16'h0011, 1'b0, 1'b1);
      step(16'h0000, 1'b1, 1'b1);

      // single requester, request dropped during grant
      step(16'h0000, 1'b0, 1'b1);
      step(16'h0002, 1'b0, 1'b1);
      step(16'h0000, 1'b1, 1'b1);
      step(16'h0000, 1'b1, 1'b1);

      // round robin across all lines, from a reset pointer
      step(16'h0000, 1'b0, 1'b0);
      for (int i = 0; i < 34; i++) begin
         step(16'hFFFF, 1'b0, 1'b1);
         step(16'hFFFF, 1'b1, 1'b1);
      end

      // wrap priority
      step(16'h4000, 1'b0, 1'b1);
      step(16'h0000, 1'b1, 1'b1);
      step(16'h4001, 1'b0, 1'b1);
      step(16'h0000, 1'b1, 1'b1);
      step(16'hC000, 1'b0, 1'b1);
      step(16'h0000, 1'b1, 1'b1);

      // no ack: timeout build revokes after MAX_HOLD, otherwise held
      step(16'h0100, 1'b0, 1'b1);
      for (int i = 0; i < 6; i++) step(16'h0000, 1'b0, 1'b1);
      step(16'hFFFF, 1'b0, 1'b1);
      step(16'h0000, 1'b1, 1'b1);
      step(16'h0000, 1'b1, 1'b1);

      // ack in the final hold cycle wins over expiry
      step(16'h0008, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) step(16'h0000, 1'b0, 1'b1);
      step(16'h0000, 1'b1, 1'b1);
      step(16'h0000, 1'b0, 1'b1);

      // long hold without ack
      step(16'h0020, 1'b0, 1'b1);
      for (int i = 0; i < 300; i++) step(16'h0000, 1'b0, 1'b1);
      step(16'h0000, 1'b1, 1'b1);
      step(16'h0000, 1'b1, 1'b1);

      // randomized traffic
      for (int i = 0; i < 2000; i++) begin
         mode = $urandom_range(0, 3);
         case (mode)
            0:       r = 16'h0000;
            1:       r = 16'h0001 << $urandom_range(0, 15);
            2:       r = 16'($urandom);
            default: r = 16'hFFFF;
         endcase
         step(r, ($urandom_range(0, 2) == 0), ($urandom_range(0, 199) != 0));
      end

      // drain and confirm every expected event was observed
      for (int i = 0; i < 4; i++) step(16'h0000, 1'b1, 1'b1);
      total++;
      if (gq.size() != 0 || rq.size() != 0) begin
         bad++;
         $display("FAIL drain got pending grants=%0d releases=%0d want 0/0",
                  gq.size(), rq.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
